// File: rtl/big_sm_template.sv
// DDR3 command sequencer following the simplified JEDEC device state diagram.
// Moore decode of the state register drives the active-low CS/RAS/CAS/WE pins.
module big_sm_template (
  input  logic CLK,
  input  logic RESET,
  input  logic ZQCL,
  input  logic MRS,
  input  logic SRE,
  input  logic SRX,
  input  logic REF,
  input  logic PDE,
  input  logic PDX,
  input  logic CKE,
  input  logic ACT,
  input  logic WRITE,
  input  logic READ,
  input  logic WRITE_AP,
  input  logic READ_AP,
  input  logic PRE,
  output logic CS,
  output logic RAS,
  output logic CAS,
  output logic WE
);

  typedef enum logic [4:0] {
    POWER_ON       = 5'd0,
    RESET_PROC     = 5'd1,
    INIT           = 5'd2,
    ZQ_CAL         = 5'd3,
    IDLE           = 5'd4,
    WRITE_LEVELING = 5'd5,
    SELF_REFRESH   = 5'd6,
    REFRESHING     = 5'd7,
    PRECHARGE_PD   = 5'd8,
    ACTIVATING     = 5'd9,
    BANK_ACTIVE    = 5'd10,
    WRITING        = 5'd11,
    READING        = 5'd12,
    WRITING_AP     = 5'd13,
    READING_AP     = 5'd14,
    PRECHARGING    = 5'd15,
    ACTIVE_PD      = 5'd16
  } state_t;

  state_t state;
  state_t state_nxt;
  logic [3:0] cmd;

  always_ff @(posedge CLK) begin
    if (RESET) state <= POWER_ON;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      POWER_ON:   state_nxt = RESET_PROC;
      RESET_PROC: state_nxt = INIT;
      INIT:       if (ZQCL) state_nxt = ZQ_CAL;
      ZQ_CAL:     if (!ZQCL) state_nxt = IDLE;
      IDLE: begin
        if (REF)              state_nxt = REFRESHING;
        else if (SRE && !CKE) state_nxt = SELF_REFRESH;
        else if (PDE && !CKE) state_nxt = PRECHARGE_PD;
        else if (MRS)         state_nxt = WRITE_LEVELING;
        else if (ZQCL)        state_nxt = ZQ_CAL;
        else if (ACT)         state_nxt = ACTIVATING;
      end
      WRITE_LEVELING: if (!MRS) state_nxt = IDLE;
      REFRESHING:     if (!REF) state_nxt = IDLE;
      SELF_REFRESH:   if (SRX && CKE) state_nxt = IDLE;
      PRECHARGE_PD:   if (PDX && CKE) state_nxt = IDLE;
      ACTIVATING:     state_nxt = BANK_ACTIVE;
      BANK_ACTIVE, WRITING, READING: begin
        if (WRITE_AP)     state_nxt = WRITING_AP;
        else if (READ_AP) state_nxt = READING_AP;
        else if (WRITE)   state_nxt = WRITING;
        else if (READ)    state_nxt = READING;
        else if (PRE)     state_nxt = PRECHARGING;
        else if (state == BANK_ACTIVE) begin
          if (PDE && !CKE) state_nxt = ACTIVE_PD;
        end
        else state_nxt = BANK_ACTIVE;
      end
      WRITING_AP, READING_AP: state_nxt = PRECHARGING;
      PRECHARGING: state_nxt = IDLE;
      ACTIVE_PD:   if (PDX && CKE) state_nxt = BANK_ACTIVE;
      default:     state_nxt = POWER_ON;
    endcase
  end

  always_comb begin
    cmd = 4'b1111;
    unique case (state)
      POWER_ON, RESET_PROC,
      PRECHARGE_PD, ACTIVE_PD:      cmd = 4'b1111;
      INIT, IDLE, BANK_ACTIVE:      cmd = 4'b0111;
      ZQ_CAL:                       cmd = 4'b0110;
      WRITE_LEVELING:               cmd = 4'b0000;
      REFRESHING, SELF_REFRESH:     cmd = 4'b0001;
      ACTIVATING:                   cmd = 4'b0011;
      WRITING, WRITING_AP:          cmd = 4'b0100;
      READING, READING_AP:          cmd = 4'b0101;
      PRECHARGING:                  cmd = 4'b0010;
      default:                      cmd = 4'b1111;
    endcase
  end

  assign {CS, RAS, CAS, WE} = cmd;

endmodule

// File: tb/tb_big_sm_template.sv
// Scoreboard bench for big_sm_template: each step pushes the expected
// state/command, and the entry is popped and compared after the clock edge.
module tb_big_sm_template;

  logic CLK, RESET, ZQCL, MRS, SRE, SRX, REF, PDE, PDX, CKE;
  logic ACT, WRITE, READ, WRITE_AP, READ_AP, PRE;
  logic CS, RAS, CAS, WE;

  big_sm_template dut (
    .CLK(CLK), .RESET(RESET), .ZQCL(ZQCL), .MRS(MRS), .SRE(SRE),
    .SRX(SRX), .REF(REF), .PDE(PDE), .PDX(PDX), .CKE(CKE), .ACT(ACT),
    .WRITE(WRITE), .READ(READ), .WRITE_AP(WRITE_AP), .READ_AP(READ_AP),
    .PRE(PRE), .CS(CS), .RAS(RAS), .CAS(CAS), .WE(WE)
  );

  localparam logic [14:0] I_RST  = 15'h4000;
  localparam logic [14:0] I_ZQ   = 15'h2000;
  localparam logic [14:0] I_MRS  = 15'h1000;
  localparam logic [14:0] I_SRE  = 15'h0800;
  localparam logic [14:0] I_SRX  = 15'h0400;
  localparam logic [14:0] I_REF  = 15'h0200;
  localparam logic [14:0] I_PDE  = 15'h0100;
  localparam logic [14:0] I_PDX  = 15'h0080;
  localparam logic [14:0] I_CKE  = 15'h0040;
  localparam logic [14:0] I_ACT  = 15'h0020;
  localparam logic [14:0] I_WR   = 15'h0010;
  localparam logic [14:0] I_RD   = 15'h0008;
  localparam logic [14:0] I_WRAP = 15'h0004;
  localparam logic [14:0] I_RDAP = 15'h0002;
  localparam logic [14:0] I_PRE  = 15'h0001;
  localparam logic [14:0] I_NONE = 15'h0000;

  typedef struct packed {
    logic [14:0] in;
    logic [4:0]  st;
    logic [3:0]  cmd;
  } step_t;

  typedef struct packed {
    logic [4:0] st;
    logic [3:0] cmd;
  } exp_t;

  exp_t sb [$];
  int checks = 0;
  int errors = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic step_t mk(logic [14:0] in, logic [4:0] st,
                               logic [3:0] cmd);
    step_t s;
    s.in = in;
    s.st = st;
    s.cmd = cmd;
    return s;
  endfunction

  task automatic apply(input step_t s);
    {RESET, ZQCL, MRS, SRE, SRX, REF, PDE, PDX, CKE,
     ACT, WRITE, READ, WRITE_AP, READ_AP, PRE} = s.in;
    sb.push_back({s.st, s.cmd});
  endtask

  task automatic test_reset();
    step_t s [$];
    exp_t e;
    s.push_back(mk(I_RST,  5'd0, 4'b1111));
    s.push_back(mk(I_NONE, 5'd1, 4'b1111));
    s.push_back(mk(I_NONE, 5'd2, 4'b0111));
    s.push_back(mk(I_NONE, 5'd2, 4'b0111));
    s.push_back(mk(I_ZQ,   5'd3, 4'b0110));
    s.push_back(mk(I_ZQ,   5'd3, 4'b0110));
    s.push_back(mk(I_NONE, 5'd4, 4'b0111));
    foreach (s[i]) begin
      apply(s[i]);
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({dut.state, CS, RAS, CAS, WE} !== {e.st, e.cmd}) begin
        errors++;
        $display("FAIL reset step %0d: got st=%0d cmd=%b, exp st=%0d cmd=%b",
                 i, dut.state, {CS, RAS, CAS, WE}, e.st, e.cmd);
      end
    end
  endtask

  task automatic test_idle_modes();
    step_t s [$];
    exp_t e;
    s.push_back(mk(I_MRS,  5'd5, 4'b0000));
    s.push_back(mk(I_MRS,  5'd5, 4'b0000));
    s.push_back(mk(I_NONE, 5'd4, 4'b0111));
    s.push_back(mk(I_REF,  5'd7, 4'b0001));
    s.push_back(mk(I_REF,  5'd7, 4'b0001));
    s.push_back(mk(I_NONE, 5'd4, 4'b0111));
    s.push_back(mk(I_RD,   5'd4, 4'b0111));
    s.push_back(mk(I_PDE | I_CKE, 5'd4, 4'b0111));
    s.push_back(mk(I_REF | I_MRS | I_ACT | I_ZQ, 5'd7, 4'b0001));
    s.push_back(mk(I_NONE, 5'd4, 4'b0111));
    s.push_back(mk(I_MRS | I_ZQ | I_ACT, 5'd5, 4'b0000));
    s.push_back(mk(I_NONE, 5'd4, 4'b0111));
    s.push_back(mk(I_ZQ | I_ACT, 5'd3, 4'b0110));
    s.push_back(mk(I_NONE, 5'd4, 4'b0111));
    foreach (s[i]) begin
      apply(s[i]);
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({dut.state, CS, RAS, CAS, WE} !== {e.st, e.cmd}) begin
        errors++;
        $display("FAIL idle_modes step %0d: got st=%0d cmd=%b, exp st=%0d cmd=%b",
                 i, dut.state, {CS, RAS, CAS, WE}, e.st, e.cmd);
      end
    end
  endtask

  task automatic test_bank_rw();
    step_t s [$];
    exp_t e;
    s.push_back(mk(I_ACT,  5'd9,  4'b0011));
    s.push_back(mk(I_NONE, 5'd10, 4'b0111));
    s.push_back(mk(I_NONE, 5'd10, 4'b0111));
    s.push_back(mk(I_WR,   5'd11, 4'b0100));
    s.push_back(mk(I_WR,   5'd11, 4'b0100));
    s.push_back(mk(I_RD,   5'd12, 4'b0101));
    s.push_back(mk(I_PRE,  5'd15, 4'b0010));
    s.push_back(mk(I_NONE, 5'd4,  4'b0111));
    s.push_back(mk(I_ACT,  5'd9,  4'b0011));
    s.push_back(mk(I_RD,   5'd10, 4'b0111));
    s.push_back(mk(I_RD,   5'd12, 4'b0101));
    s.push_back(mk(I_PDE,  5'd10, 4'b0111));
    s.push_back(mk(I_WR | I_RD | I_PRE, 5'd11, 4'b0100));
    s.push_back(mk(I_NONE, 5'd10, 4'b0111));
    s.push_back(mk(I_RD | I_PRE, 5'd12, 4'b0101));
    s.push_back(mk(I_PRE,  5'd15, 4'b0010));
    s.push_back(mk(I_NONE, 5'd4,  4'b0111));
    foreach (s[i]) begin
      apply(s[i]);
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({dut.state, CS, RAS, CAS, WE} !== {e.st, e.cmd}) begin
        errors++;
        $display("FAIL bank_rw step %0d: got st=%0d cmd=%b, exp st=%0d cmd=%b",
                 i, dut.state, {CS, RAS, CAS, WE}, e.st, e.cmd);
      end
    end
  endtask

  task automatic test_auto_precharge();
    step_t s [$];
    exp_t e;
    s.push_back(mk(I_ACT,  5'd9,  4'b0011));
    s.push_back(mk(I_NONE, 5'd10, 4'b0111));
    s.push_back(mk(I_RDAP, 5'd14, 4'b0101));
    s.push_back(mk(I_RDAP, 5'd15, 4'b0010));
    s.push_back(mk(I_NONE, 5'd4,  4'b0111));
    s.push_back(mk(I_ACT,  5'd9,  4'b0011));
    s.push_back(mk(I_NONE, 5'd10, 4'b0111));
    s.push_back(mk(I_WRAP | I_RD, 5'd13, 4'b0100));
    s.push_back(mk(I_NONE, 5'd15, 4'b0010));
    s.push_back(mk(I_NONE, 5'd4,  4'b0111));
    s.push_back(mk(I_ACT,  5'd9,  4'b0011));
    s.push_back(mk(I_WR,   5'd10, 4'b0111));
    s.push_back(mk(I_WR,   5'd11, 4'b0100));
    s.push_back(mk(I_RDAP | I_WR | I_RD, 5'd14, 4'b0101));
    s.push_back(mk(I_NONE, 5'd15, 4'b0010));
    s.push_back(mk(I_NONE, 5'd4,  4'b0111));
    foreach (s[i]) begin
      apply(s[i]);
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({dut.state, CS, RAS, CAS, WE} !== {e.st, e.cmd}) begin
        errors++;
        $display("FAIL auto_precharge step %0d: got st=%0d cmd=%b, exp st=%0d cmd=%b",
                 i, dut.state, {CS, RAS, CAS, WE}, e.st, e.cmd);
      end
    end
  endtask

  task automatic test_power_down();
    step_t s [$];
    exp_t e;
    s.push_back(mk(I_SRE,  5'd6,  4'b0001));
    s.push_back(mk(I_SRX,  5'd6,  4'b0001));
    s.push_back(mk(I_CKE,  5'd6,  4'b0001));
    s.push_back(mk(I_SRX | I_CKE, 5'd4, 4'b0111));
    s.push_back(mk(I_SRE | I_PDE, 5'd6, 4'b0001));
    s.push_back(mk(I_SRX | I_CKE, 5'd4, 4'b0111));
    s.push_back(mk(I_PDE,  5'd8,  4'b1111));
    s.push_back(mk(I_PDX,  5'd8,  4'b1111));
    s.push_back(mk(I_PDX | I_CKE, 5'd4, 4'b0111));
    s.push_back(mk(I_ACT,  5'd9,  4'b0011));
    s.push_back(mk(I_NONE, 5'd10, 4'b0111));
    s.push_back(mk(I_PDE | I_CKE, 5'd10, 4'b0111));
    s.push_back(mk(I_PDE,  5'd16, 4'b1111));
    s.push_back(mk(I_PDX | I_RD, 5'd16, 4'b1111));
    s.push_back(mk(I_PDX | I_CKE, 5'd10, 4'b0111));
    s.push_back(mk(I_PRE,  5'd15, 4'b0010));
    s.push_back(mk(I_NONE, 5'd4,  4'b0111));
    foreach (s[i]) begin
      apply(s[i]);
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({dut.state, CS, RAS, CAS, WE} !== {e.st, e.cmd}) begin
        errors++;
        $display("FAIL power_down step %0d: got st=%0d cmd=%b, exp st=%0d cmd=%b",
                 i, dut.state, {CS, RAS, CAS, WE}, e.st, e.cmd);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    step_t s [$];
    exp_t e;
    s.push_back(mk(I_ACT,  5'd9,  4'b0011));
    s.push_back(mk(I_NONE, 5'd10, 4'b0111));
    s.push_back(mk(I_WR,   5'd11, 4'b0100));
    s.push_back(mk(I_WR | I_RST, 5'd0, 4'b1111));
    s.push_back(mk(I_WR,   5'd1,  4'b1111));
    s.push_back(mk(I_NONE, 5'd2,  4'b0111));
    s.push_back(mk(I_ZQ,   5'd3,  4'b0110));
    s.push_back(mk(I_NONE, 5'd4,  4'b0111));
    foreach (s[i]) begin
      apply(s[i]);
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({dut.state, CS, RAS, CAS, WE} !== {e.st, e.cmd}) begin
        errors++;
        $display("FAIL reset_mid_op step %0d: got st=%0d cmd=%b, exp st=%0d cmd=%b",
                 i, dut.state, {CS, RAS, CAS, WE}, e.st, e.cmd);
      end
    end
  endtask

  initial begin
    {RESET, ZQCL, MRS, SRE, SRX, REF, PDE, PDX, CKE,
     ACT, WRITE, READ, WRITE_AP, READ_AP, PRE} = '0;
    test_reset();
    test_idle_modes();
    test_bank_rw();
    test_auto_precharge();
    test_power_down();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
